// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants, state encoding and beat-offset helper for the cache line <-> burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BURST_WIDTH = 64;
  localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CNT_W       = $clog2(BEATS);
  localparam int unsigned LINE_IDX_W  = $clog2(LINE_WIDTH);

  // Clears the byte-offset bits so the burst always starts on a line boundary.
  localparam logic [ADDR_WIDTH-1:0] LINE_ADDR_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef logic [1:0] adaptor_state_t;

  localparam adaptor_state_t ST_IDLE  = 2'd0;
  localparam adaptor_state_t ST_READ  = 2'd1;
  localparam adaptor_state_t ST_WRITE = 2'd2;
  localparam adaptor_state_t ST_DONE  = 2'd3;

  function automatic logic [LINE_IDX_W-1:0] beat_lsb(input logic [CNT_W-1:0] beat);
    return LINE_IDX_W'(beat) << $clog2(BURST_WIDTH);
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit cache line transfers into four 64-bit memory beats (low beat first)
// and reassembles read beats into a line; all outputs come straight from flops.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  adaptor_state_t         state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [LINE_WIDTH-1:0]  wline, wline_next;
  logic [LINE_WIDTH-1:0]  rline_next;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [BURST_WIDTH-1:0] burst_next;
  logic                   read_next, write_next, resp_next;
  logic                   last_beat;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // State, beat counter, line buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wline     <= '0;
      line_o    <= '0;
      address_o <= '0;
      burst_o   <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      wline     <= wline_next;
      line_o    <= rline_next;
      address_o <= addr_next;
      burst_o   <= burst_next;
      read_o    <= read_next;
      write_o   <= write_next;
      resp_o    <= resp_next;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state
  // so they line up with the state they describe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wline_next = wline;
    rline_next = line_o;
    addr_next  = address_o;

    case (state)
      ST_IDLE: begin
        if (write_i) begin
          addr_next  = address_i & LINE_ADDR_MASK;
          wline_next = line_i;
          cnt_next   = '0;
          state_next = ST_WRITE;
        end else if (read_i) begin
          addr_next  = address_i & LINE_ADDR_MASK;
          cnt_next   = '0;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (resp_i) begin
          rline_next[beat_lsb(cnt) +: BURST_WIDTH] = burst_i;
          cnt_next = cnt + CNT_W'(1);
          if (last_beat) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (resp_i) begin
          cnt_next = cnt + CNT_W'(1);
          if (last_beat) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    read_next  = (state_next == ST_READ);
    write_next = (state_next == ST_WRITE);
    resp_next  = (state_next == ST_DONE);
    burst_next = wline_next[beat_lsb(cnt_next) +: BURST_WIDTH];
  end

endmodule
